// File: rtl/count_decoder.sv
// count_decoder: builds the 7-bit thermometer word for a 3-bit count, one bit per cycle, MSB first; define COUNT_DECODER_SERIAL_EN to expose the serial bit stream
module count_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_count,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_x,
  output logic [1:0] out_class,
  output logic       ser_valid,
  output logic       ser_bit
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d, k_q, k_d, rem;
  logic [6:0] x_q, x_d;
  logic [1:0] cls_q, cls_d;
  logic       b;
  assign rem       = 3'd6 - k_q;
  assign b         = rem < cnt_q;
  assign out_x     = x_q;
  assign out_class = cls_q;
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      k_q     <= 3'd0;
      x_q     <= 7'd0;
      cls_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      x_q     <= x_d;
      cls_q   <= cls_d;
    end
  end
  // accept a count, shift in one bit per cycle until k reaches 6, then hold until the result is taken
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    x_d       = x_q;
    cls_d     = cls_q;
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    case (state_q)
      IDLE: if (in_valid) begin
        cnt_d   = in_count;
        cls_d   = {1'b0, in_count[0]} + {1'b0, in_count[1]} + {1'b0, in_count[2]};
        x_d     = 7'd0;
        k_d     = 3'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        x_d     = {x_q[5:0], b};
        k_d     = k_q == 3'd6 ? k_q : k_q + 3'd1;
        state_d = k_q == 3'd6 ? DONE : SHIFT;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef COUNT_DECODER_SERIAL_EN
  assign ser_valid = state_q == SHIFT;
  assign ser_bit   = ser_valid & b;
`else
  assign ser_valid = 1'b0;
  assign ser_bit   = 1'b0;
`endif
endmodule

// File: tb/tb_count_decoder.sv
// tb_count_decoder: cycle-level reference model of the count decoder with directed and random stimulus
module tb_count_decoder;
`ifdef COUNT_DECODER_SERIAL_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] in_count = 3'd0;
  logic       in_ready, out_valid, ser_valid, ser_bit;
  logic [6:0] out_x;
  logic [1:0] out_class;
  int n_chk = 0, n_err = 0;
  int ncyc = 0, act_t = -1, act_c = 0, acc_last = 0, acc_prev = 0;

  count_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_class(out_class),
    .ser_valid(ser_valid), .ser_bit(ser_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, ncyc);
    end
  endtask

  // Model: a transaction accepted at negedge a shifts during the 7 following cycles and
  // presents the word with `count` low ones from the 8th onward until taken.
  always @(negedge clk) begin
    int d, w;
    bit busy, ov, sh;
    ncyc++;
    if (rst) begin
      act_t = -1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_x", out_x, 0);
      check("rst_out_class", out_class, 0);
      check("rst_ser_valid", ser_valid, 0);
      check("rst_ser_bit", ser_bit, 0);
    end else begin
      busy = act_t >= 0;
      d    = ncyc - act_t;
      w    = (1 << act_c) - 1;
      ov   = busy && d >= 8;
      sh   = busy && d >= 1 && d <= 7;
      check("in_ready", in_ready, !busy);
      check("out_valid", out_valid, ov);
      check("ser_valid", ser_valid, SER && sh);
      check("ser_bit", ser_bit, SER && sh && ((w >> (7 - d)) & 1) == 1);
      if (ov) begin
        check("out_x", out_x, w);
        check("out_class", out_class, $countones(act_c));
      end
      if (ov && out_ready) begin
        check("roundtrip", $countones(out_x), act_c);
        act_t = -1;
      end else if (!busy && in_valid) begin
        act_t    = ncyc;
        act_c    = int'(in_count);
        acc_prev = acc_last;
        acc_last = ncyc;
      end
    end
  end

  task automatic send(input logic [2:0] c);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_count = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && act_t >= 0; i++) @(posedge clk);
    if (act_t >= 0) check("timeout", 0, 1);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(3'd5);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_in_ready", in_ready, 1);
    check("async_out_valid", out_valid, 0);
    check("async_out_x", out_x, 0);
    check("async_out_class", out_class, 0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send(3'd2);
    wait_idle();
    for (int c = 0; c < 8; c++) begin
      send(3'(c));
      wait_idle();
    end
    out_ready = 1'b0;
    send(3'd6);
    repeat (7) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_count = 3'd1;
    repeat (10) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_count = 3'd3;
    @(posedge clk); #1;
    in_count = 3'd4;
    repeat (9) @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_spacing", acc_last - acc_prev, 9);
    wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_count  = 3'($urandom_range(0, 7));
      out_ready = $urandom_range(0, 3) != 0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
